// File: rtl/vxe_regio_params.sv
// ---------------------------------------------------------------------------
// vxe_regio_params
// Purpose : Shared constants for the vxe_regio register block: register
//           indices, the fixed ID value and field widths/bit positions.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package vxe_regio_params;

   localparam int unsigned REG_IDX_W     = 10;
   localparam int unsigned REG_DATA_W    = 32;

   // Register indices
   localparam logic [REG_IDX_W-1:0] IDX_ID             = 10'd0;
   localparam logic [REG_IDX_W-1:0] IDX_CTRL           = 10'd1;
   localparam logic [REG_IDX_W-1:0] IDX_STATUS         = 10'd2;
   localparam logic [REG_IDX_W-1:0] IDX_INTR_ACT       = 10'd3;
   localparam logic [REG_IDX_W-1:0] IDX_INTR_MSK       = 10'd4;
   localparam logic [REG_IDX_W-1:0] IDX_INTR_RAW       = 10'd5;
   localparam logic [REG_IDX_W-1:0] IDX_PGM_ADDR_LO    = 10'd6;
   localparam logic [REG_IDX_W-1:0] IDX_PGM_ADDR_HI    = 10'd7;
   localparam logic [REG_IDX_W-1:0] IDX_START          = 10'd8;
   localparam logic [REG_IDX_W-1:0] IDX_FAULT_ADDR_LO  = 10'd9;
   localparam logic [REG_IDX_W-1:0] IDX_FAULT_ADDR_HI  = 10'd10;
   localparam logic [REG_IDX_W-1:0] IDX_FAULT_INSTR_LO = 10'd11;
   localparam logic [REG_IDX_W-1:0] IDX_FAULT_INSTR_HI = 10'd12;

   // Fixed identification value
   localparam logic [REG_DATA_W-1:0] ID_VALUE = 32'h5645_0100;

   // Field positions and widths
   localparam int unsigned CTRL_MAS_SEL_BIT = 0;
   localparam int unsigned STATUS_BUSY_BIT  = 0;
   localparam int unsigned INTR_W           = 4;
   localparam int unsigned PGM_ADDR_W       = 37;
   localparam int unsigned PGM_ADDR_HI_W    = PGM_ADDR_W - 32;
   localparam int unsigned INSTR_W          = 64;

endpackage

// File: rtl/vxe_regio.sv
// ---------------------------------------------------------------------------
// vxe_regio
// Purpose : Register I/O block between a simple read/write request bus and
//           the control unit / interrupt unit. Single-cycle request, response
//           one cycle later, no backpressure.
// Config  : define VXE_REGIO_FAULT_REGS_EN to implement the fault capture
//           registers at indices 9-12; otherwise they decode as unmapped.
// Ports   :
//   clk, rst                   clock, synchronous active-high reset
//   i_wreg_idx/i_wdata/i_wenable  write request
//   o_waccept/o_werror         write response (one-cycle pulse)
//   i_rreg_idx/i_renable       read request
//   o_rdata/o_raccept/o_rerror read response (rdata holds between reads)
//   i_cu_busy, i_cu_last_instr_addr/data   control unit status inputs
//   o_cu_pgm_addr, o_cu_start, o_cu_mas_sel control unit outputs
//   i_intu_raw/act, o_intu_msk, o_intu_ack_vld/ack  interrupt unit
// ---------------------------------------------------------------------------
module vxe_regio
   import vxe_regio_params::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [9:0]            i_wreg_idx,
   input  logic [31:0]           i_wdata,
   input  logic                  i_wenable,
   output logic                  o_waccept,
   output logic                  o_werror,
   input  logic [9:0]            i_rreg_idx,
   input  logic                  i_renable,
   output logic [31:0]           o_rdata,
   output logic                  o_raccept,
   output logic                  o_rerror,
   input  logic                  i_cu_busy,
   input  logic [36:0]           i_cu_last_instr_addr,
   input  logic [63:0]           i_cu_last_instr_data,
   output logic [36:0]           o_cu_pgm_addr,
   output logic                  o_cu_start,
   input  logic [3:0]            i_intu_raw,
   input  logic [3:0]            i_intu_act,
   output logic [3:0]            o_intu_msk,
   output logic                  o_intu_ack_vld,
   output logic [3:0]            o_intu_ack,
   output logic                  o_cu_mas_sel
);

   logic                  r_mas_sel;
   logic [INTR_W-1:0]     r_intu_msk;
   logic [PGM_ADDR_W-1:0] r_pgm_addr;
   logic                  r_cu_start;
   logic                  r_intu_ack_vld;
   logic [INTR_W-1:0]     r_intu_ack;
   logic                  r_waccept;
   logic                  r_werror;
   logic                  r_raccept;
   logic                  r_rerror;
   logic [31:0]           r_rdata;

   logic [31:0]           w_rdata;
   logic                  w_rerror;
   logic                  w_werror;
   logic                  w_start_req;
   logic                  w_ack_req;

`ifndef VXE_REGIO_FAULT_REGS_EN
   // Fault capture inputs are intentionally ignored in this build.
   logic w_unused_fault;
   assign w_unused_fault = ^{i_cu_last_instr_addr, i_cu_last_instr_data};
`endif

   // Read decode: the value is taken from the current register contents, so
   // a read that coincides with a write to the same register sees the old
   // value. Narrow fields are zero-extended.
   always_comb begin
      w_rdata  = '0;
      w_rerror = 1'b0;
      case (i_rreg_idx)
         IDX_ID:          w_rdata = ID_VALUE;
         IDX_CTRL:        w_rdata[CTRL_MAS_SEL_BIT] = r_mas_sel;
         IDX_STATUS:      w_rdata[STATUS_BUSY_BIT] = i_cu_busy;
         IDX_INTR_ACT:    w_rdata[INTR_W-1:0] = i_intu_act;
         IDX_INTR_MSK:    w_rdata[INTR_W-1:0] = r_intu_msk;
         IDX_INTR_RAW:    w_rdata[INTR_W-1:0] = i_intu_raw;
         IDX_PGM_ADDR_LO: w_rdata = r_pgm_addr[31:0];
         IDX_PGM_ADDR_HI: w_rdata[PGM_ADDR_HI_W-1:0] = r_pgm_addr[PGM_ADDR_W-1:32];
         IDX_START:       w_rdata = '0;
`ifdef VXE_REGIO_FAULT_REGS_EN
         IDX_FAULT_ADDR_LO:  w_rdata = i_cu_last_instr_addr[31:0];
         IDX_FAULT_ADDR_HI:  w_rdata[PGM_ADDR_HI_W-1:0] = i_cu_last_instr_addr[PGM_ADDR_W-1:32];
         IDX_FAULT_INSTR_LO: w_rdata = i_cu_last_instr_data[31:0];
         IDX_FAULT_INSTR_HI: w_rdata = i_cu_last_instr_data[INSTR_W-1:32];
`else
         IDX_FAULT_ADDR_LO, IDX_FAULT_ADDR_HI,
         IDX_FAULT_INSTR_LO, IDX_FAULT_INSTR_HI: w_rerror = 1'b1;
`endif
         default:         w_rerror = 1'b1;
      endcase
   end

   // Write decode: classifies the write target. Read-only and unmapped
   // indices report an error; START is refused while the control unit is busy.
   always_comb begin
      w_werror    = 1'b0;
      w_start_req = 1'b0;
      w_ack_req   = 1'b0;
      case (i_wreg_idx)
         IDX_CTRL, IDX_INTR_MSK, IDX_PGM_ADDR_LO, IDX_PGM_ADDR_HI: w_werror = 1'b0;
         IDX_INTR_ACT: w_ack_req = 1'b1;
         IDX_START: begin
            if (i_cu_busy) begin
               w_werror = 1'b1;
            end else begin
               w_start_req = 1'b1;
            end
         end
         default: w_werror = 1'b1;
      endcase
   end

   // Write side state: configuration registers, one-cycle response and
   // side-effect pulses. The acknowledge value is sticky between writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mas_sel      <= 1'b0;
         r_intu_msk     <= '0;
         r_pgm_addr     <= '0;
         r_cu_start     <= 1'b0;
         r_intu_ack_vld <= 1'b0;
         r_intu_ack     <= '0;
         r_waccept      <= 1'b0;
         r_werror       <= 1'b0;
      end else begin
         r_waccept      <= i_wenable;
         r_werror       <= i_wenable & w_werror;
         r_cu_start     <= i_wenable & w_start_req;
         r_intu_ack_vld <= i_wenable & w_ack_req;
         if (i_wenable && w_ack_req) begin
            r_intu_ack <= i_wdata[INTR_W-1:0];
         end
         if (i_wenable) begin
            case (i_wreg_idx)
               IDX_CTRL:        r_mas_sel <= i_wdata[CTRL_MAS_SEL_BIT];
               IDX_INTR_MSK:    r_intu_msk <= i_wdata[INTR_W-1:0];
               IDX_PGM_ADDR_LO: r_pgm_addr[31:0] <= i_wdata;
               IDX_PGM_ADDR_HI: r_pgm_addr[PGM_ADDR_W-1:32] <= i_wdata[PGM_ADDR_HI_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // Read side state: response pulse plus registered data. Data only loads
   // on a read so it holds its value between accesses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_raccept <= 1'b0;
         r_rerror  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_raccept <= i_renable;
         r_rerror  <= i_renable & w_rerror;
         if (i_renable) begin
            r_rdata <= w_rdata;
         end
      end
   end

   assign o_waccept      = r_waccept;
   assign o_werror       = r_werror;
   assign o_raccept      = r_raccept;
   assign o_rerror       = r_rerror;
   assign o_rdata        = r_rdata;
   assign o_cu_pgm_addr  = r_pgm_addr;
   assign o_cu_start     = r_cu_start;
   assign o_intu_msk     = r_intu_msk;
   assign o_intu_ack_vld = r_intu_ack_vld;
   assign o_intu_ack     = r_intu_ack;
   assign o_cu_mas_sel   = r_mas_sel;

endmodule

// File: tb/tb_vxe_regio.sv
// ---------------------------------------------------------------------------
// tb_vxe_regio
// Purpose : Directed self-checking bench for vxe_regio. Honors
//           VXE_REGIO_FAULT_REGS_EN for the expected fault register values.
// Ports   : none
// ---------------------------------------------------------------------------
module tb_vxe_regio;

   logic        clk;
   logic        rst;
   logic [9:0]  i_wreg_idx;
   logic [31:0] i_wdata;
   logic        i_wenable;
   logic        o_waccept;
   logic        o_werror;
   logic [9:0]  i_rreg_idx;
   logic        i_renable;
   logic [31:0] o_rdata;
   logic        o_raccept;
   logic        o_rerror;
   logic        i_cu_busy;
   logic [36:0] i_cu_last_instr_addr;
   logic [63:0] i_cu_last_instr_data;
   logic [36:0] o_cu_pgm_addr;
   logic        o_cu_start;
   logic [3:0]  i_intu_raw;
   logic [3:0]  i_intu_act;
   logic [3:0]  o_intu_msk;
   logic        o_intu_ack_vld;
   logic [3:0]  o_intu_ack;
   logic        o_cu_mas_sel;

   int checks = 0;
   int errors = 0;

   vxe_regio dut (
      .clk                  (clk),
      .rst                  (rst),
      .i_wreg_idx           (i_wreg_idx),
      .i_wdata              (i_wdata),
      .i_wenable            (i_wenable),
      .o_waccept            (o_waccept),
      .o_werror             (o_werror),
      .i_rreg_idx           (i_rreg_idx),
      .i_renable            (i_renable),
      .o_rdata              (o_rdata),
      .o_raccept            (o_raccept),
      .o_rerror             (o_rerror),
      .i_cu_busy            (i_cu_busy),
      .i_cu_last_instr_addr (i_cu_last_instr_addr),
      .i_cu_last_instr_data (i_cu_last_instr_data),
      .o_cu_pgm_addr        (o_cu_pgm_addr),
      .o_cu_start           (o_cu_start),
      .i_intu_raw           (i_intu_raw),
      .i_intu_act           (i_intu_act),
      .o_intu_msk           (o_intu_msk),
      .o_intu_ack_vld       (o_intu_ack_vld),
      .o_intu_ack           (o_intu_ack),
      .o_cu_mas_sel         (o_cu_mas_sel)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one request cycle (read and/or write) starting at a falling edge
   // and returns at the next falling edge, i.e. in the middle of the
   // response cycle where outputs are stable.
   task automatic applyStimulus(input logic doRd, input logic [9:0] rIdx,
                                input logic doWr, input logic [9:0] wIdx,
                                input logic [31:0] wData);
      @(negedge clk);
      i_renable  = doRd;
      i_rreg_idx = rIdx;
      i_wenable  = doWr;
      i_wreg_idx = wIdx;
      i_wdata    = wData;
      @(negedge clk);
      i_renable  = 1'b0;
      i_wenable  = 1'b0;
   endtask

   // Idle cycle: returns at the next falling edge with no request issued.
   task automatic idleCycle();
      @(negedge clk);
   endtask

   // One comparison; counts it and reports tag/observed/expected on failure.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst                  = 1'b1;
      i_wreg_idx           = '0;
      i_wdata              = '0;
      i_wenable            = 1'b0;
      i_rreg_idx           = '0;
      i_renable            = 1'b0;
      i_cu_busy            = 1'b0;
      i_cu_last_instr_addr = '0;
      i_cu_last_instr_data = '0;
      i_intu_raw           = 4'h0;
      i_intu_act           = 4'h0;

      // Requests pending while in reset must be dropped
      repeat (2) @(negedge clk);
      i_renable  = 1'b1;
      i_rreg_idx = 10'd0;
      i_wenable  = 1'b1;
      i_wreg_idx = 10'd1;
      i_wdata    = 32'h1;
      @(negedge clk);
      checkOutput("rst_raccept", o_raccept, 0);
      checkOutput("rst_waccept", o_waccept, 0);
      checkOutput("rst_rdata", o_rdata, 0);
      checkOutput("rst_mas_sel", o_cu_mas_sel, 0);
      checkOutput("rst_pgm_addr", o_cu_pgm_addr, 0);
      checkOutput("rst_msk", o_intu_msk, 0);
      checkOutput("rst_ack", {o_intu_ack_vld, o_intu_ack}, 0);
      checkOutput("rst_start", o_cu_start, 0);
      rst       = 1'b0;
      i_renable = 1'b0;
      i_wenable = 1'b0;
      idleCycle();
      checkOutput("post_rst_raccept", o_raccept, 0);
      checkOutput("post_rst_waccept", o_waccept, 0);

      // Read ID
      applyStimulus(1, 10'd0, 0, 10'd0, 32'h0);
      checkOutput("id_raccept", o_raccept, 1);
      checkOutput("id_rdata", o_rdata, 64'h5645_0100);
      checkOutput("id_rerror", o_rerror, 0);
      idleCycle();
      checkOutput("id_raccept_end", o_raccept, 0);
      checkOutput("id_rdata_hold", o_rdata, 64'h5645_0100);

      // START while busy, then while idle
      i_cu_busy = 1'b1;
      applyStimulus(0, 10'd0, 1, 10'd8, 32'h1);
      checkOutput("start_busy_waccept", o_waccept, 1);
      checkOutput("start_busy_werror", o_werror, 1);
      checkOutput("start_busy_pulse", o_cu_start, 0);
      i_cu_busy = 1'b0;
      applyStimulus(0, 10'd0, 1, 10'd8, 32'h1);
      checkOutput("start_waccept", o_waccept, 1);
      checkOutput("start_werror", o_werror, 0);
      checkOutput("start_pulse", o_cu_start, 1);
      idleCycle();
      checkOutput("start_pulse_end", o_cu_start, 0);
      checkOutput("start_waccept_end", o_waccept, 0);

      // CTRL and INTR_MSK
      applyStimulus(0, 10'd0, 1, 10'd1, 32'h1);
      checkOutput("ctrl_mas_sel", o_cu_mas_sel, 1);
      applyStimulus(0, 10'd0, 1, 10'd4, 32'hdddd_ddde);
      checkOutput("msk_out", o_intu_msk, 4'he);
      checkOutput("msk_werror", o_werror, 0);
      applyStimulus(1, 10'd4, 0, 10'd0, 32'h0);
      checkOutput("msk_readback", o_rdata, 32'h0000_000e);

      // Interrupt acknowledge
      applyStimulus(0, 10'd0, 1, 10'd3, 32'hdddd_dddc);
      checkOutput("ack_vld", o_intu_ack_vld, 1);
      checkOutput("ack_val", o_intu_ack, 4'hc);
      idleCycle();
      checkOutput("ack_vld_end", o_intu_ack_vld, 0);
      checkOutput("ack_hold", o_intu_ack, 4'hc);

      // Program address
      applyStimulus(0, 10'd0, 1, 10'd6, 32'hcafe_beef);
      applyStimulus(0, 10'd0, 1, 10'd7, 32'hdddd_abba);
      checkOutput("pgm_addr", o_cu_pgm_addr, 37'h1a_cafe_beef);
      applyStimulus(1, 10'd7, 0, 10'd0, 32'h0);
      checkOutput("pgm_hi_read", o_rdata, 32'h1a);

      // Fault registers and unmapped read
      i_cu_last_instr_addr = 37'h1f_0102_0304;
      i_cu_last_instr_data = 64'hbeef_deaf_cafe_feed;
`ifdef VXE_REGIO_FAULT_REGS_EN
      applyStimulus(1, 10'd9, 0, 10'd0, 32'h0);
      checkOutput("fault_addr_lo", {o_rerror, o_rdata}, {1'b0, 32'h0102_0304});
      applyStimulus(1, 10'd10, 0, 10'd0, 32'h0);
      checkOutput("fault_addr_hi", {o_rerror, o_rdata}, {1'b0, 32'h1f});
      applyStimulus(1, 10'd11, 0, 10'd0, 32'h0);
      checkOutput("fault_instr_lo", {o_rerror, o_rdata}, {1'b0, 32'hcafe_feed});
      applyStimulus(1, 10'd12, 0, 10'd0, 32'h0);
      checkOutput("fault_instr_hi", {o_rerror, o_rdata}, {1'b0, 32'hbeef_deaf});
`else
      applyStimulus(1, 10'd9, 0, 10'd0, 32'h0);
      checkOutput("fault_addr_lo", {o_rerror, o_rdata}, {1'b1, 32'h0});
      applyStimulus(1, 10'd10, 0, 10'd0, 32'h0);
      checkOutput("fault_addr_hi", {o_rerror, o_rdata}, {1'b1, 32'h0});
      applyStimulus(1, 10'd11, 0, 10'd0, 32'h0);
      checkOutput("fault_instr_lo", {o_rerror, o_rdata}, {1'b1, 32'h0});
      applyStimulus(1, 10'd12, 0, 10'd0, 32'h0);
      checkOutput("fault_instr_hi", {o_rerror, o_rdata}, {1'b1, 32'h0});
`endif
      applyStimulus(1, 10'h3ff, 0, 10'd0, 32'h0);
      checkOutput("unmapped_read", {o_raccept, o_rerror, o_rdata}, {1'b1, 1'b1, 32'h0});
      idleCycle();
      checkOutput("rerror_end", o_rerror, 0);

      // Reading START returns zero without error
      applyStimulus(1, 10'd8, 0, 10'd0, 32'h0);
      checkOutput("start_read", {o_rerror, o_rdata}, {1'b0, 32'h0});

      // Writes to RO and unmapped indices: error and no state change
      applyStimulus(0, 10'd0, 1, 10'd0, 32'h0);
      checkOutput("ro_write_werror", o_werror, 1);
      applyStimulus(0, 10'd0, 1, 10'h3ff, 32'h0);
      checkOutput("unmapped_write_werror", o_werror, 1);
      checkOutput("unmapped_write_state",
                  {o_cu_mas_sel, o_intu_msk, o_cu_pgm_addr},
                  {1'b1, 4'he, 37'h1a_cafe_beef});

      // Status and interrupt input reads
      i_cu_busy  = 1'b1;
      i_intu_raw = 4'h5;
      i_intu_act = 4'h9;
      applyStimulus(1, 10'd2, 0, 10'd0, 32'h0);
      checkOutput("status_busy", o_rdata, 32'h1);
      applyStimulus(1, 10'd5, 0, 10'd0, 32'h0);
      checkOutput("intr_raw", o_rdata, 32'h5);
      applyStimulus(1, 10'd3, 0, 10'd0, 32'h0);
      checkOutput("intr_act", o_rdata, 32'h9);
      i_cu_busy = 1'b0;

      // Simultaneous read and write of CTRL: read sees old value
      applyStimulus(1, 10'd1, 1, 10'd1, 32'h0);
      checkOutput("rw_same_rdata", o_rdata, 32'h1);
      checkOutput("rw_same_accepts", {o_raccept, o_waccept, o_rerror, o_werror}, 4'b1100);
      checkOutput("rw_same_mas_sel", o_cu_mas_sel, 0);

      // Synchronous reset clears configuration state
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst2_state",
                  {o_cu_mas_sel, o_intu_msk, o_cu_pgm_addr, o_intu_ack, o_rdata},
                  0);
      rst = 1'b0;
      idleCycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vxe_regio.md
VXE_REGIO -- requirements
Module: vxe_regio

Interface
REQ-001 SHALL use one clock and a synchronous active-high reset; all state updates on the rising edge of clk.
REQ-002 SHALL have ports (name  dir  width  meaning):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_wreg_idx  in  10  write register index
- i_wdata  in  32  write data
- i_wenable  in  1  write request, one cycle per request
- o_waccept  out  1  write done pulse
- o_werror  out  1  write error, valid with o_waccept
- i_rreg_idx  in  10  read register index
- i_renable  in  1  read request, one cycle per request
- o_rdata  out  32  read data, valid with o_raccept
- o_raccept  out  1  read done pulse
- o_rerror  out  1  read error, valid with o_raccept
- i_cu_busy  in  1  control unit busy
- i_cu_last_instr_addr  in  37  last (faulting) instruction address
- i_cu_last_instr_data  in  64  last instruction word
- o_cu_pgm_addr  out  37  program start address
- o_cu_start  out  1  start pulse to control unit
- i_intu_raw  in  4  raw interrupt lines
- i_intu_act  in  4  active interrupts
- o_intu_msk  out  4  interrupt mask
- o_intu_ack_vld  out  1  acknowledge strobe
- o_intu_ack  out  4  acknowledge bits
- o_cu_mas_sel  out  1  master select, CTRL bit 0

Function
REQ-003 SHALL decode this register map (index, access, content):
- 0 ID  RO  0x5645_0100
- 1 CTRL  RW  bit 0 = mas_sel
- 2 STATUS  RO  bit 0 = i_cu_busy
- 3 INTR_ACT  R: i_intu_act; W: acknowledge
- 4 INTR_MSK  RW  bits [3:0]
- 5 INTR_RAW  RO  i_intu_raw
- 6 PGM_ADDR_LO  RW  addr[31:0]
- 7 PGM_ADDR_HI  RW  addr[36:32] in bits [4:0]
- 8 START  WO
- 9 FAULT_INSTR_ADDR_LO  RO  last_instr_addr[31:0]
- 10 FAULT_INSTR_ADDR_HI  RO  last_instr_addr[36:32]
- 11 FAULT_INSTR_LO  RO  last_instr_data[31:0]
- 12 FAULT_INSTR_HI  RO  last_instr_data[63:32]
REQ-004 SHALL zero-extend all narrow read fields; unused write bits are ignored.
REQ-005 Read path: i_renable at cycle N SHALL produce o_raccept=1 for exactly cycle N+1, with o_rdata and o_rerror registered; there is no backpressure.
REQ-006 Reading START SHALL return 0 without error; any unmapped index SHALL return 0 with o_rerror=1.
REQ-007 Write path: i_wenable at cycle N SHALL produce o_waccept=1 for exactly cycle N+1, with o_werror; the register update is visible from N+1.
REQ-008 Writes to RO or unmapped indices SHALL set o_werror=1 and change no state.
REQ-009 START write with i_cu_busy=0 SHALL pulse o_cu_start for exactly cycle N+1; with i_cu_busy=1 it SHALL set o_werror=1 and produce no pulse.
REQ-010 INTR_ACT write SHALL drive o_intu_ack=wdata[3:0] and pulse o_intu_ack_vld for cycle N+1; o_intu_ack holds its value afterwards.
REQ-011 o_cu_pgm_addr, o_intu_msk and o_cu_mas_sel SHALL reflect their registers continuously.
REQ-012 Simultaneous read and write SHALL be serviced independently in the same cycle; a read of the register being written returns the old value.
REQ-013 Outside accept cycles, o_raccept, o_waccept, o_rerror, o_werror, o_cu_start and o_intu_ack_vld SHALL be 0; o_rdata holds its last value.

Reset
REQ-014 While rst=1, every output and register SHALL be 0; a request pending during reset is dropped with no accept.

Configuration
REQ-015 When macro VXE_REGIO_FAULT_REGS_EN is defined, indices 9-12 SHALL be implemented as specified; when it is undefined they SHALL behave as unmapped (read 0 with o_rerror=1; write gives o_werror=1).

Structure
REQ-016 Register index constants, the ID value and field bit positions SHALL live in the shared package/include vxe_regio_params.
REQ-017 The block SHALL be a single flat module with no sub-module.

Verification
REQ-018 After reset, read ID -> o_raccept one cycle later, o_rdata=0x5645_0100, o_rerror=0.
REQ-019 With i_cu_busy=1, write START -> o_werror=1 and no o_cu_start; then with i_cu_busy=0, write START -> o_cu_start one-cycle pulse and o_werror=0.
REQ-020 Write CTRL=0x1 -> o_cu_mas_sel=1; write INTR_MSK=0xdddd_ddde -> o_intu_msk=0xe, and reading INTR_MSK back returns 0x0000_000e.
REQ-021 Write INTR_ACT=0xdddd_dddc -> o_intu_ack_vld pulse with o_intu_ack=0xc.
REQ-022 Write PGM_ADDR_LO=0xcafe_beef, then PGM_ADDR_HI=0xdddd_abba -> o_cu_pgm_addr=0x1a_cafe_beef.
REQ-023 With i_cu_last_instr_addr=0x1f_0102_0304 and i_cu_last_instr_data=0xbeef_deaf_cafe_feed, reads of indices 9-12 -> 0x0102_0304, 0x1f, 0xcafe_feed, 0xbeef_deaf; read index 0x3ff -> o_rerror=1.
